// File: rtl/regfile_multiport.sv
// Multi-port register file with hardwired-zero r0 and a per-register busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_multiport #(
    parameter int unsigned N  = 32,
    parameter int unsigned W  = 32,
    parameter int unsigned NR = 2,
    parameter int unsigned NW = 2,
    localparam int unsigned A = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NR*A-1:0] rd_addr,
    output logic [NR*W-1:0] rd_data,
    output logic [NR-1:0]   rd_busy,
    input  logic [NW-1:0]   wr_en,
    input  logic [NW*A-1:0] wr_addr,
    input  logic [NW*W-1:0] wr_data,
    input  logic            iss_en,
    input  logic [A-1:0]    iss_addr,
    output logic            any_busy
);

    if ((N < 2) || ((N & (N - 1)) != 0)) begin : gen_bad_n
        $error("regfile_multiport: N must be a power of two >= 2");
    end
    if ((NR < 1) || (NR > 4)) begin : gen_bad_nr
        $error("regfile_multiport: NR must be in 1..4");
    end
    if ((NW < 1) || (NW > 2)) begin : gen_bad_nw
        $error("regfile_multiport: NW must be in 1..2");
    end

    logic [W-1:0] regs_q [N];
    logic [W-1:0] regs_d [N];
    logic [N-1:0] busy_q;
    logic [N-1:0] busy_d;

    // Later write ports overwrite earlier ones; the issue set is applied last so it wins.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int unsigned j = 0; j < NW; j++) begin
            if (wr_en[j] && (wr_addr[j*A +: A] != '0)) begin
                regs_d[wr_addr[j*A +: A]] = wr_data[j*W +: W];
                busy_d[wr_addr[j*A +: A]] = 1'b0;
            end
        end
        if (iss_en && (iss_addr != '0)) begin
            busy_d[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned k = 0; k < N; k++) begin
                regs_q[k] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            rd_data[i*W +: W] = regs_q[rd_addr[i*A +: A]];
            rd_busy[i]        = busy_q[rd_addr[i*A +: A]];
`ifdef REGFILE_BYPASS_EN
            for (int unsigned j = 0; j < NW; j++) begin
                if (wr_en[j] && (wr_addr[j*A +: A] != '0) &&
                    (wr_addr[j*A +: A] == rd_addr[i*A +: A])) begin
                    rd_data[i*W +: W] = wr_data[j*W +: W];
                    rd_busy[i]        = iss_en && (iss_addr == rd_addr[i*A +: A]);
                end
            end
`endif
        end
    end

    assign any_busy = |busy_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard-driven self-checking bench for regfile_multiport (default parameters).
module tb_regfile_multiport;

    localparam int unsigned N  = 32;
    localparam int unsigned W  = 32;
    localparam int unsigned NR = 2;
    localparam int unsigned NW = 2;
    localparam int unsigned A  = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR*A-1:0] rd_addr;
    logic [NR*W-1:0] rd_data;
    logic [NR-1:0]   rd_busy;
    logic [NW-1:0]   wr_en;
    logic [NW*A-1:0] wr_addr;
    logic [NW*W-1:0] wr_data;
    logic            iss_en;
    logic [A-1:0]    iss_addr;
    logic            any_busy;

    regfile_multiport #(.N(N), .W(W), .NR(NR), .NW(NW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .any_busy (any_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int unsigned port;
        logic [31:0] data;
        logic        busy;
    } rd_exp_t;

    rd_exp_t     sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic        any_chk  = 1'b0;
    logic        exp_any  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_rd(input string tag, input int unsigned port, input logic [A-1:0] addr,
                             input logic [31:0] data, input logic busy);
        rd_expect_push(tag, port, addr, data, busy);
    endtask

    task automatic rd_expect_push(input string tag, input int unsigned port,
                                  input logic [A-1:0] addr, input logic [31:0] data,
                                  input logic busy);
        rd_exp_t e;
        rd_addr[port*A +: A] = addr;
        e.tag  = tag;
        e.port = port;
        e.data = data;
        e.busy = busy;
        sb.push_back(e);
    endtask

    task automatic expect_any(input logic v);
        any_chk = 1'b1;
        exp_any = v;
    endtask

    task automatic wr(input int unsigned port, input logic [A-1:0] addr, input logic [31:0] data);
        wr_en[port]          = 1'b1;
        wr_addr[port*A +: A] = addr;
        wr_data[port*W +: W] = data;
    endtask

    task automatic iss(input logic [A-1:0] addr);
        iss_en   = 1'b1;
        iss_addr = addr;
    endtask

    // Compare everything queued for this cycle, then commit the edge and go idle.
    task automatic step();
        rd_exp_t e;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq({e.tag, "_data"}, rd_data[e.port*W +: W], e.data);
            check_eq({e.tag, "_busy"}, {31'd0, rd_busy[e.port]}, {31'd0, e.busy});
        end
        if (any_chk) check_eq("any_busy", {31'd0, any_busy}, {31'd0, exp_any});
        any_chk = 1'b0;
        @(posedge clk);
        #1;
        wr_en   = '0;
        iss_en  = 1'b0;
        rd_addr = '0;
    endtask

    logic bp;

    initial begin
`ifdef REGFILE_BYPASS_EN
        bp = 1'b1;
`else
        bp = 1'b0;
`endif
        rst = 1'b0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // Reset state
        expect_rd("rst_r5", 0, 5, 32'h0, 1'b0);
        expect_rd("rst_r31", 1, 31, 32'h0, 1'b0);
        expect_any(1'b0);
        step();

        // Write then reset clears it
        wr(0, 5, 32'hDEADBEEF); step();
        expect_rd("wr_r5", 0, 5, 32'hDEADBEEF, 1'b0); step();
        rst = 1'b0; step(); rst = 1'b1;
        expect_rd("rst2_r5", 0, 5, 32'h0, 1'b0);
        expect_any(1'b0);
        step();

        // Zero register
        wr(0, 0, 32'hFFFFFFFF); wr(1, 0, 32'hFFFFFFFF); iss(0); step();
        expect_rd("r0_p0", 0, 0, 32'h0, 1'b0);
        expect_rd("r0_p1", 1, 0, 32'h0, 1'b0);
        expect_any(1'b0);
        step();

        // Dual write
        wr(0, 3, 32'h11); wr(1, 7, 32'h22); step();
        expect_rd("dual_r3", 0, 3, 32'h11, 1'b0);
        expect_rd("dual_r7", 1, 7, 32'h22, 1'b0);
        step();

        // Collision on r9 after issuing it: port 1 wins and busy clears
        iss(9); step();
        expect_rd("iss_r9", 0, 9, 32'h0, 1'b1); expect_any(1'b1); step();
        wr(0, 9, 32'hAA); wr(1, 9, 32'hBB); step();
        expect_rd("coll_r9", 0, 9, 32'hBB, 1'b0);
        expect_rd("coll_r9b", 1, 9, 32'hBB, 1'b0);
        expect_any(1'b0);
        step();

        // Scoreboard on r4
        iss(4); step();
        expect_rd("sb_iss_r4", 1, 4, 32'h0, 1'b1); expect_any(1'b1); step();
        wr(0, 4, 32'h55); step();
        expect_rd("sb_wr_r4", 1, 4, 32'h55, 1'b0); expect_any(1'b0); step();
        iss(4); wr(1, 4, 32'h66); step();
        expect_rd("sb_both_r4", 0, 4, 32'h66, 1'b1); expect_any(1'b1); step();
        wr(0, 4, 32'h77); step();
        expect_rd("sb_clr_r4", 0, 4, 32'h77, 1'b0); expect_any(1'b0); step();

        // Bypass / same-cycle write visibility
        wr(0, 12, 32'hAAAA); step();
        wr(0, 12, 32'h1234);
        expect_rd("byp_r12", 1, 12, bp ? 32'h1234 : 32'hAAAA, 1'b0);
        step();
        expect_rd("byp_next_r12", 1, 12, 32'h1234, 1'b0); step();
        iss(12); step();
        wr(0, 12, 32'h5678);
        expect_rd("byp_busy_r12", 0, 12, bp ? 32'h5678 : 32'h1234, !bp);
        expect_any(1'b1);
        step();
        expect_rd("byp_after_r12", 0, 12, 32'h5678, 1'b0); expect_any(1'b0); step();
        wr(0, 13, 32'h1); wr(1, 13, 32'h2);
        expect_rd("byp_coll_r13", 1, 13, bp ? 32'h2 : 32'h0, 1'b0);
        step();
        expect_rd("coll_next_r13", 1, 13, 32'h2, 1'b0); step();

        // Reset mid-operation
        iss(8); step();
        rst = 1'b0; wr(0, 10, 32'hC0FFEE); wr(1, 11, 32'hBEEF); iss(14); step();
        rst = 1'b1;
        expect_rd("rmid_r10", 0, 10, 32'h0, 1'b0);
        expect_rd("rmid_r11", 1, 11, 32'h0, 1'b0);
        expect_any(1'b0);
        step();
        expect_rd("rmid_r8", 0, 8, 32'h0, 1'b0);
        expect_rd("rmid_r14", 1, 14, 32'h0, 1'b0);
        step();
        expect_rd("rmid_r3", 0, 3, 32'h0, 1'b0);
        expect_rd("rmid_r12", 1, 12, 32'h0, 1'b0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
